// File: rtl/zepto_control_unit_if.sv
// Instruction-fetch handshake between the zepto control unit (master) and instruction memory (slave).
// The request and address are held by the master until the memory acknowledges.
interface zepto_control_unit_if #(
  parameter int PC_W = 8
);
  logic            Ctrl_imem_req;
  logic [PC_W-1:0] Ctrl_pc;
  logic            Ctrl_imem_ack;
  logic [15:0]     Ctrl_imem_data;

  modport master (
    output Ctrl_imem_req, Ctrl_pc,
    input  Ctrl_imem_ack, Ctrl_imem_data
  );

  modport slave (
    input  Ctrl_imem_req, Ctrl_pc,
    output Ctrl_imem_ack, Ctrl_imem_data
  );
endinterface

// File: rtl/zepto_control_unit.sv
// Zepto multi-cycle control FSM: FETCH/DECODE/EXECUTE/WRITEBACK, 4 cycles per ALU op with same-cycle ack.
// Fetch stalls with req and PC held until imem ack; CTRL_TRACE_EN adds retired-instruction trace outputs.
module zepto_control_unit #(
  parameter int PC_W = 8
) (
  input  logic        Ctrl_clk,
  input  logic        Ctrl_rst_n,
  input  logic        Ctrl_run,
  zepto_control_unit_if.master imem,
  output logic [3:0]  Ctrl_Ra_addr,
  output logic [3:0]  Ctrl_Rb_addr,
  output logic [3:0]  Ctrl_Rd_addr,
  output logic        Ctrl_rf_we,
  output logic [3:0]  Ctrl_Ula_sel,
  output logic [15:0] Ctrl_Ula_Imm,
  output logic        Ctrl_Bsel,
  output logic [15:0] Ctrl_Bconst,
  output logic        Ctrl_illegal,
  output logic        Ctrl_halted
`ifdef CTRL_TRACE_EN
  ,
  output logic [15:0] Ctrl_retired,
  output logic [15:0] Ctrl_last_ir
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            req;

  logic [3:0]      op;
  logic [15:0]     identity;
  logic [PC_W-1:0] jmp_target;

  assign op         = ir[15:12];
  // AND needs all-ones as its neutral operand; every other ALU op is neutral with zero.
  assign identity   = (op[2:0] == 3'd2) ? 16'hFFFF : 16'h0000;
  assign jmp_target = PC_W'(ir[7:0]);

  assign imem.Ctrl_imem_req = req;
  assign imem.Ctrl_pc       = pc;

  // Undefined opcodes: 0101..0111 and 1101.
  function automatic logic op_illegal(input logic [3:0] o);
    return (o[2:0] > 3'd4) && !(o[3] && (o[2:1] == 2'b11));
  endfunction

  always_ff @(posedge Ctrl_clk or negedge Ctrl_rst_n) begin
    if (!Ctrl_rst_n) begin
      state        <= S_IDLE;
      pc           <= '0;
      ir           <= '0;
      req          <= 1'b0;
      Ctrl_Ra_addr <= '0;
      Ctrl_Rb_addr <= '0;
      Ctrl_Rd_addr <= '0;
      Ctrl_rf_we   <= 1'b0;
      Ctrl_Ula_sel <= '0;
      Ctrl_Ula_Imm <= '0;
      Ctrl_Bsel    <= 1'b1;
      Ctrl_Bconst  <= '0;
      Ctrl_illegal <= 1'b0;
      Ctrl_halted  <= 1'b0;
`ifdef CTRL_TRACE_EN
      Ctrl_retired <= '0;
      Ctrl_last_ir <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Ctrl_run) begin
            req   <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (req && imem.Ctrl_imem_ack) begin
            ir           <= imem.Ctrl_imem_data;
            req          <= 1'b0;
            // Raised here so the pulse coincides with the DECODE cycle.
            Ctrl_illegal <= op_illegal(imem.Ctrl_imem_data[15:12]);
            state        <= S_DECODE;
          end
        end
        S_DECODE: begin
          Ctrl_illegal <= 1'b0;
          if (op_illegal(op)) begin
            pc    <= pc + PC_W'(1);
            req   <= 1'b1;
            state <= S_FETCH;
          end else if (op == 4'hF) begin
            Ctrl_halted <= 1'b1;
            state       <= S_HALT;
          end else if (op == 4'hE) begin
            pc    <= jmp_target;
            req   <= 1'b1;
            state <= S_FETCH;
`ifdef CTRL_TRACE_EN
            Ctrl_retired <= Ctrl_retired + 16'd1;
            Ctrl_last_ir <= ir;
`endif
          end else begin
            Ctrl_Ula_sel <= {1'b0, op[2:0]};
            Ctrl_Bsel    <= ~op[3];
            Ctrl_Ula_Imm <= op[3] ? {{12{ir[3]}}, ir[3:0]} : identity;
            Ctrl_Bconst  <= op[3] ? identity : 16'h0000;
            Ctrl_Ra_addr <= ir[7:4];
            Ctrl_Rb_addr <= ir[3:0];
            Ctrl_Rd_addr <= ir[11:8];
            state        <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          Ctrl_rf_we <= 1'b1;
          state      <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          Ctrl_rf_we <= 1'b0;
          pc         <= pc + PC_W'(1);
          req        <= 1'b1;
          state      <= S_FETCH;
`ifdef CTRL_TRACE_EN
          Ctrl_retired <= Ctrl_retired + 16'd1;
          Ctrl_last_ir <= ir;
`endif
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zepto_control_unit.sv
// Bench for zepto_control_unit: imem responder with programmable ack delay, writeback monitor and
// expected-result queue compared against observed writebacks.
module tb_zepto_control_unit;
  localparam int PC_W = 8;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] imm;
    logic        bsel;
    logic [15:0] bconst;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rd;
    logic [7:0]  pc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  ra, rb, rd, sel;
  logic        we, bsel, illegal, halted;
  logic [15:0] imm, bconst;
`ifdef CTRL_TRACE_EN
  logic [15:0] retired, last_ir;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] imem [256];
  int   ack_delay = 0;
  bit   rand_delay = 1'b0;
  int   cur_delay = 0;
  int   wait_cnt = 0;

  rec_t        exp_q[$];
  rec_t        obs_q[$];
  logic [7:0]  fetch_q[$];
  int          reqlen_q[$];
  int          we_wide, ill_cnt, ill_wide, pc_moved, req_len;
  logic        we_prev, ill_prev, req_prev;
  logic [7:0]  pc_prev;

  zepto_control_unit_if #(.PC_W(PC_W)) ifc ();

  zepto_control_unit #(.PC_W(PC_W)) dut (
    .Ctrl_clk     (clk),
    .Ctrl_rst_n   (rst_n),
    .Ctrl_run     (run),
    .imem         (ifc),
    .Ctrl_Ra_addr (ra),
    .Ctrl_Rb_addr (rb),
    .Ctrl_Rd_addr (rd),
    .Ctrl_rf_we   (we),
    .Ctrl_Ula_sel (sel),
    .Ctrl_Ula_Imm (imm),
    .Ctrl_Bsel    (bsel),
    .Ctrl_Bconst  (bconst),
    .Ctrl_illegal (illegal),
    .Ctrl_halted  (halted)
`ifdef CTRL_TRACE_EN
    ,
    .Ctrl_retired (retired),
    .Ctrl_last_ir (last_ir)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: acks after the programmed delay; drives a HALT word when not acking.
  initial begin
    ifc.Ctrl_imem_ack  = 1'b0;
    ifc.Ctrl_imem_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n || !ifc.Ctrl_imem_req) begin
        ifc.Ctrl_imem_ack  = 1'b0;
        ifc.Ctrl_imem_data = 16'hF000;
        wait_cnt = 0;
        if (!rst_n) fetch_q.delete();
      end else begin
        if (wait_cnt == 0) cur_delay = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
        if (wait_cnt >= cur_delay) begin
          ifc.Ctrl_imem_ack  = 1'b1;
          ifc.Ctrl_imem_data = imem[ifc.Ctrl_pc];
          fetch_q.push_back(ifc.Ctrl_pc);
        end else begin
          ifc.Ctrl_imem_ack  = 1'b0;
          ifc.Ctrl_imem_data = 16'hF000;
          wait_cnt++;
        end
      end
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        obs_q.delete(); reqlen_q.delete();
        we_wide = 0; ill_cnt = 0; ill_wide = 0; pc_moved = 0; req_len = 0;
        we_prev = 1'b0; ill_prev = 1'b0; req_prev = 1'b0; pc_prev = '0;
      end else begin
        if (we === 1'b1) begin
          obs_q.push_back({sel, imm, bsel, bconst, ra, rb, rd, ifc.Ctrl_pc});
          if (we_prev) we_wide++;
        end
        if (illegal === 1'b1) begin
          ill_cnt++;
          if (ill_prev) ill_wide++;
        end
        if (ifc.Ctrl_imem_req === 1'b1) begin
          if (req_prev && ifc.Ctrl_pc !== pc_prev) pc_moved++;
          req_len++;
        end else if (req_prev) begin
          reqlen_q.push_back(req_len);
          req_len = 0;
        end
        we_prev = (we === 1'b1); ill_prev = (illegal === 1'b1);
        req_prev = (ifc.Ctrl_imem_req === 1'b1); pc_prev = ifc.Ctrl_pc;
      end
    end
  end

  function automatic rec_t model(input logic [15:0] w, input logic [7:0] pc);
    rec_t r;
    logic [15:0] ident;
    ident = (w[14:12] == 3'd2) ? 16'hFFFF : 16'h0000;
    r.ra = w[7:4]; r.rb = w[3:0]; r.rd = w[11:8]; r.pc = pc;
    if (!w[15]) begin
      r.sel = w[15:12]; r.bsel = 1'b1; r.imm = ident; r.bconst = 16'h0000;
    end else begin
      r.sel = {1'b0, w[14:12]}; r.bsel = 1'b0; r.imm = {{12{w[3]}}, w[3:0]}; r.bconst = ident;
    end
    return r;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0; run = 1'b0; ack_delay = 0; rand_delay = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [60:0] got, want;
    rst_n = 1'b0; run = 1'b0;
    repeat (2) @(negedge clk);
    got  = {ifc.Ctrl_imem_req, ifc.Ctrl_pc, ra, rb, rd, we, sel, imm, bsel, bconst, illegal, halted};
    want = {1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
    n_cmp++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", got, want);
    end
`ifdef CTRL_TRACE_EN
    n_cmp++;
    if (retired !== 16'h0 || last_ir !== 16'h0) begin
      n_fail++; $display("FAIL reset_trace got=%h/%h want=0/0", retired, last_ir);
    end
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifc.Ctrl_imem_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_run_req got=%b want=0", ifc.Ctrl_imem_req);
    end
  endtask

  task automatic test_alu_basic();
    int reqs;
    int n_obs;
    rec_t e;
    reset_dut();
    imem[0] = 16'h0312; imem[1] = 16'h2512; imem[2] = 16'hA51F; imem[3] = 16'h8A0C; imem[4] = 16'hF000;
    exp_q.push_back({4'h0, 16'h0000, 1'b1, 16'h0000, 4'h1, 4'h2, 4'h3, 8'h00});
    exp_q.push_back({4'h2, 16'hFFFF, 1'b1, 16'h0000, 4'h1, 4'h2, 4'h5, 8'h01});
    exp_q.push_back({4'h2, 16'hFFFF, 1'b0, 16'hFFFF, 4'h1, 4'hF, 4'h5, 8'h02});
    exp_q.push_back({4'h0, 16'hFFFC, 1'b0, 16'h0000, 4'h0, 4'hC, 4'hA, 8'h03});
    run = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ifc.Ctrl_imem_req !== 1'b1) begin
      n_fail++; $display("FAIL req_cycle1 got=%b want=1", ifc.Ctrl_imem_req);
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (we !== 1'b1) begin
      n_fail++; $display("FAIL we_cycle4 got=%b want=1", we);
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.Ctrl_pc !== 8'h01 || we !== 1'b0) begin
      n_fail++; $display("FAIL pc_after_wb got pc=%h we=%b want pc=01 we=0", ifc.Ctrl_pc, we);
    end
    wait_halt(200);
    n_cmp++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_reached got=%b want=1", halted);
    end
    run = 1'b1;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.Ctrl_imem_req !== 1'b0 || we !== 1'b0) reqs++;
    end
    run = 1'b0;
    n_cmp++;
    if (reqs !== 0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_sticky got busy_cycles=%0d halted=%b want 0/1", reqs, halted);
    end
    n_obs = obs_q.size();
    n_cmp++;
    if (n_obs !== 4) begin
      n_fail++; $display("FAIL alu_wb_count got=%0d want=4", n_obs);
    end
    for (int i = 0; i < 4 && i < n_obs; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q[i] !== e) begin
        n_fail++; $display("FAIL alu_wb%0d got=%h want=%h", i, obs_q[i], e);
      end
    end
  endtask

  task automatic test_delayed_ack_jmp();
    logic [7:0] want_pc [4];
    rec_t e;
    reset_dut();
    ack_delay = 3;
    want_pc[0] = 8'h00; want_pc[1] = 8'h01; want_pc[2] = 8'hFF; want_pc[3] = 8'h00;
    imem[0] = 16'h1456; imem[1] = 16'hE0FF; imem[8'hFF] = 16'h0123;
    exp_q.push_back({4'h1, 16'h0000, 1'b1, 16'h0000, 4'h5, 4'h6, 4'h4, 8'h00});
    exp_q.push_back({4'h0, 16'h0000, 1'b1, 16'h0000, 4'h2, 4'h3, 4'h1, 8'hFF});
    run = 1'b1;
    for (int i = 0; i < 300 && fetch_q.size() < 4; i++) @(negedge clk);
    run = 1'b0;
    n_cmp++;
    if (fetch_q.size() < 4) begin
      n_fail++; $display("FAIL fetch_count got=%0d want>=4", fetch_q.size());
    end
    for (int i = 0; i < 4 && i < fetch_q.size(); i++) begin
      n_cmp++;
      if (fetch_q[i] !== want_pc[i]) begin
        n_fail++; $display("FAIL fetch_pc%0d got=%h want=%h", i, fetch_q[i], want_pc[i]);
      end
    end
    n_cmp++;
    if (reqlen_q.size() < 1 || reqlen_q[0] !== 4) begin
      n_fail++; $display("FAIL req_hold got=%0d want=4", reqlen_q.size() > 0 ? reqlen_q[0] : -1);
    end
    n_cmp++;
    if (pc_moved !== 0) begin
      n_fail++; $display("FAIL pc_stable_in_fetch got=%0d changes want=0", pc_moved);
    end
    wait_obs(2, 100);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== e) begin
        n_fail++; $display("FAIL jmp_wb%0d got=%h want=%h", i, (i < obs_q.size()) ? obs_q[i] : rec_t'(0), e);
      end
    end
  endtask

  task automatic test_illegal();
    rec_t e;
    reset_dut();
    imem[0] = 16'h7000; imem[1] = 16'h0312; imem[2] = 16'hF000;
    exp_q.push_back({4'h0, 16'h0000, 1'b1, 16'h0000, 4'h1, 4'h2, 4'h3, 8'h01});
    run = 1'b1;
    wait_halt(200);
    run = 1'b0;
    n_cmp++;
    if (ill_cnt !== 1 || ill_wide !== 0) begin
      n_fail++; $display("FAIL illegal_pulse got cnt=%0d wide=%0d want 1/0", ill_cnt, ill_wide);
    end
    n_cmp++;
    if (fetch_q.size() !== 3 || fetch_q[1] !== 8'h01) begin
      n_fail++; $display("FAIL illegal_pc_inc got fetches=%0d want 3 with pc1=01", fetch_q.size());
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_q.size() !== 1 || obs_q[0] !== e) begin
      n_fail++; $display("FAIL illegal_no_we got n=%0d first=%h want n=1 %h", obs_q.size(),
                         (obs_q.size() > 0) ? obs_q[0] : rec_t'(0), e);
    end
  endtask

  task automatic test_reset_mid_fetch();
    int i;
    reset_dut();
    ack_delay = 6;
    imem[0] = 16'h0312; imem[1] = 16'h0312;
    run = 1'b1;
    for (i = 0; i < 200 && !(ifc.Ctrl_imem_req === 1'b1 && ifc.Ctrl_pc === 8'h01); i++) @(negedge clk);
    n_cmp++;
    if (!(ifc.Ctrl_imem_req === 1'b1 && ifc.Ctrl_pc === 8'h01)) begin
      n_fail++; $display("FAIL second_fetch got req=%b pc=%h want 1/01", ifc.Ctrl_imem_req, ifc.Ctrl_pc);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ifc.Ctrl_imem_req !== 1'b0 || ifc.Ctrl_pc !== 8'h00) begin
      n_fail++; $display("FAIL async_reset got req=%b pc=%h want 0/00", ifc.Ctrl_imem_req, ifc.Ctrl_pc);
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] w;
    int n_obs;
    rec_t e;
    reset_dut();
    rand_delay = 1'b1;
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(0, 9));
      if (op > 4'd4) op = op + 4'd3;
      w = {op, 12'($urandom)};
      imem[i] = w;
      exp_q.push_back(model(w, 8'(i)));
    end
    run = 1'b1;
    wait_halt(2000);
    run = 1'b0;
    n_obs = obs_q.size();
    n_cmp++;
    if (n_obs !== 20 || we_wide !== 0) begin
      n_fail++; $display("FAIL random_count got n=%0d wide_we=%0d want 20/0", n_obs, we_wide);
    end
    for (int i = 0; i < n_obs && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q[i] !== e) begin
        n_fail++; $display("FAIL random_wb%0d got=%h want=%h", i, obs_q[i], e);
      end
    end
  endtask

`ifdef CTRL_TRACE_EN
  task automatic test_trace();
    reset_dut();
    imem[0] = 16'h0312; imem[1] = 16'h8A0C; imem[2] = 16'h2512; imem[3] = 16'hE00A; imem[10] = 16'hF000;
    run = 1'b1;
    wait_halt(200);
    run = 1'b0;
    n_cmp++;
    if (retired !== 16'd4 || last_ir !== 16'hE00A) begin
      n_fail++; $display("FAIL trace got retired=%0d last_ir=%h want 4/e00a", retired, last_ir);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_basic();
    test_delayed_ack_jmp();
    test_illegal();
    test_reset_mid_fetch();
    test_random();
`ifdef CTRL_TRACE_EN
    test_trace();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
